// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM encoding, frame geometry,
// default timeout, and the frame validity check.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DPS  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int FRAME_BITS      = 11;
    localparam int TIMEOUT_CYC_DEF = 200000;

    // Start low, stop high, odd parity over data plus parity bit.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/receptor_ps2_if.sv
// Bundle of the PS/2 line inputs and the received-byte outputs of receptor_ps2.
interface receptor_ps2_if;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic       rx_done_tick;
    logic [7:0] datos;
    logic       frame_err;

    modport master (output ps2c, ps2d, rx_en, input rx_done_tick, datos, frame_err);
    modport slave  (input ps2c, ps2d, rx_en, output rx_done_tick, datos, frame_err);
endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronizes the PS/2 lines, debounces the clock line and emits a one-cycle
// pulse on each clean falling edge of the filtered clock.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic ps2c_filt,
    output logic fall_edge,
    output logic ps2d_sync
);
    logic [1:0]            c_sync_q, c_sync_d;
    logic [1:0]            d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] shreg_q, shreg_d;
    logic                  filt_q, filt_d;
    logic                  edge_q, edge_d;

    // Next-state: synchronizers, shift filter, level hysteresis, edge detect.
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        shreg_d  = {shreg_q[FILTER_LEN-2:0], c_sync_q[1]};
        if (&shreg_q) begin
            filt_d = 1'b1;
        end else if (~|shreg_q) begin
            filt_d = 1'b0;
        end else begin
            filt_d = filt_q;
        end
        edge_d = filt_q & ~filt_d;
    end

    // Filter state registers; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            shreg_q  <= {FILTER_LEN{1'b1}};
            filt_q   <= 1'b1;
            edge_q   <= 1'b0;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            shreg_q  <= shreg_d;
            filt_q   <= filt_d;
            edge_q   <= edge_d;
        end
    end

    assign ps2c_filt = filt_q;
    assign fall_edge = edge_q;
    assign ps2d_sync = d_sync_q[1];
endmodule

// File: rtl/receptor_ps2.sv
// PS/2 keyboard receiver: collects 11-bit frames on filtered clock falling
// edges, validates them and presents the data byte with a done or error pulse.
module receptor_ps2
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] datos,
    output logic       frame_err
);
    localparam int              TW           = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      FIRST_CNT    = 4'(FRAME_BITS - 1);

    logic ps2c_filt, fall_edge, ps2d_sync;
    logic edge_s;
    logic [FRAME_BITS-1:0] shift_s;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [7:0]            datos_q, datos_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .ps2c_filt (ps2c_filt),
        .fall_edge (fall_edge),
        .ps2d_sync (ps2d_sync)
    );

    // An edge pulse always coincides with the filtered level being low.
    assign edge_s  = fall_edge & ~ps2c_filt;
    assign shift_s = {ps2d_sync, frame_q[FRAME_BITS-1:1]};

    // Receiver FSM next-state; outputs for a finished frame are decided on the
    // 11th edge so the pulse lands in the LOAD cycle.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        datos_d = datos_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_s && rx_en) begin
                    frame_d = shift_s;
                    cnt_d   = FIRST_CNT;
                    timer_d = {TW{1'b0}};
                    state_d = DPS;
                end else begin
                    state_d = IDLE;
                end
            end
            DPS: begin
                if (edge_s) begin
                    frame_d = shift_s;
                    cnt_d   = cnt_q - 4'd1;
                    timer_d = {TW{1'b0}};
                    if (cnt_q == 4'd1) begin
                        state_d = LOAD;
                        if (frame_ok(shift_s)) begin
                            datos_d = shift_s[8:1];
                            done_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = DPS;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    timer_d = {TW{1'b0}};
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            frame_q <= {FRAME_BITS{1'b0}};
            cnt_q   <= 4'd0;
            timer_q <= {TW{1'b0}};
            datos_q <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            datos_q <= datos_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_done_tick = done_q;
    assign datos        = datos_q;
    assign frame_err    = err_q;
endmodule

// File: tb/tb_receptor_ps2.sv
// Directed bench for receptor_ps2: frames are driven at 80 clk per PS/2 bit
// (12.5 kHz at a 1 MHz clk) and expected pulses are scoreboarded.
`timescale 1ns/1ps
module tb_receptor_ps2;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TO   = 500;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset;

    receptor_ps2_if bus ();

    receptor_ps2 #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c         (bus.ps2c),
        .ps2d         (bus.ps2d),
        .rx_en        (bus.rx_en),
        .rx_done_tick (bus.rx_done_tick),
        .datos        (bus.datos),
        .frame_err    (bus.frame_err)
    );

    always #500 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] model_datos = 8'h00;
    logic [7:0] datos_prev = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_err, input logic [7:0] data);
        ev_t e;
        e.is_err = is_err;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_done_tick && bus.frame_err)
                check("exclusive", {31'b0, bus.rx_done_tick & bus.frame_err}, 32'd0);
            if (bus.rx_done_tick || bus.frame_err) begin
                if (bus.rx_done_tick) done_cnt++;
                if (bus.frame_err) err_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'b0, bus.rx_done_tick, bus.frame_err}, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind_err", {31'b0, bus.frame_err}, {31'b0, e.is_err});
                    if (e.is_err) begin
                        check("datos_after_err", {24'b0, bus.datos}, {24'b0, model_datos});
                    end else begin
                        check("datos", {24'b0, bus.datos}, {24'b0, e.data});
                        model_datos = e.data;
                    end
                end
            end else if (bus.datos !== datos_prev) begin
                check("datos_stable", {24'b0, bus.datos}, {24'b0, datos_prev});
            end
        end
        datos_prev = bus.datos;
    end

    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2d = f[i];
            repeat (HALF / 2) @(negedge clk);
            bus.ps2c = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2c = 1'b1;
            if (i == glitch_bit) begin
                repeat (5) @(negedge clk);
                bus.ps2c = 1'b0;
                repeat (3) @(negedge clk);
                bus.ps2c = 1'b1;
                repeat (HALF / 2 - 8) @(negedge clk);
            end else begin
                repeat (HALF / 2) @(negedge clk);
            end
        end
        bus.ps2d = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        int d0, e0;
        reset    = 1'b1;
        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        bus.rx_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_done", {31'b0, bus.rx_done_tick}, 32'd0);
        check("rst_err", {31'b0, bus.frame_err}, 32'd0);
        check("rst_datos", {24'b0, bus.datos}, 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        repeat (20) @(negedge clk);

        push(1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        wait_drain("valid_1c");

        push(1'b0, 8'hF0);
        push(1'b0, 8'h1C);
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        wait_drain("b2b");

        push(1'b1, 8'h00);
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        wait_drain("bad_parity");

        push(1'b1, 8'h00);
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        wait_drain("bad_stop");

        e0 = err_cnt;
        push(1'b1, 8'h00);
        send_frame(8'h1C, 1'b0, 1'b1, 5, -1);
        repeat (TO + 10) @(negedge clk);
        wait_drain("timeout");
        check("timeout_err_count", err_cnt - e0, 32'd1);
        check("timeout_state", 32'(dut.state_q), 32'(IDLE));
        push(1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        wait_drain("after_timeout");

        push(1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 4);
        wait_drain("glitch");

        d0 = done_cnt;
        e0 = err_cnt;
        bus.rx_en = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        repeat (100) @(negedge clk);
        check("rx_en0_done", done_cnt - d0, 32'd0);
        check("rx_en0_err", err_cnt - e0, 32'd0);
        bus.rx_en = 1'b1;
        repeat (20) @(negedge clk);

        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 6, -1);
        reset = 1'b1;
        #1;
        check("midrst_done", {31'b0, bus.rx_done_tick}, 32'd0);
        check("midrst_err", {31'b0, bus.frame_err}, 32'd0);
        check("midrst_datos", {24'b0, bus.datos}, 32'd0);
        model_datos = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (600) @(negedge clk);
        check("post_rst_done", done_cnt - d0, 32'd0);
        check("post_rst_err", err_cnt - e0, 32'd0);
        push(1'b0, 8'hF0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
        wait_drain("after_reset_f0");
        check("final_datos", {24'b0, bus.datos}, 32'h0000_00F0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/receptor_ps2.md
RECEPTOR_PS2 -- requirements
Module: receptor_ps2

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples of ps2c needed to change the filtered clock.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200000: idle clk cycles allowed between falling edges inside a frame.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2c, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2d, input, 1 bit: raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 SHALL have port rx_en, input, 1 bit: reception enable, sampled only when in IDLE.
REQ-008 SHALL have port rx_done_tick, output, 1 bit: one-cycle pulse marking a valid byte on datos.
REQ-009 SHALL have port datos, output, 8 bits: last valid received byte, LSB first on the wire.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

Function
REQ-011 SHALL pass ps2c and ps2d each through a two-flop synchronizer before any other use.
REQ-012 SHALL shift the synchronized ps2c into a FILTER_LEN-bit register every clk.
- Filtered clock goes to 1 when the register is all ones.
- Filtered clock goes to 0 when the register is all zeros.
- Otherwise it holds its value.
REQ-013 SHALL assert the internal fall_edge for exactly one clk when the filtered clock goes from 1 to 0.
REQ-014 SHALL use an FSM with three states: IDLE, DPS and LOAD.
REQ-015 SHALL handle IDLE as follows.
- On fall_edge with rx_en=1: shift synchronized ps2d into the frame register, load bit counter with 10, go to DPS.
- On fall_edge with rx_en=0: ignore it and stay in IDLE.
REQ-016 SHALL handle DPS as follows.
- On each fall_edge: shift synchronized ps2d into the 11-bit frame register MSB-first (right shift), decrement the counter, clear the timeout counter.
- When a fall_edge arrives with counter=1: go to LOAD after that shift.
REQ-017 SHALL, in DPS, count clk cycles without fall_edge and, on reaching TIMEOUT_CYC, pulse frame_err for one cycle and return to IDLE without updating datos.
REQ-018 SHALL spend exactly one cycle in LOAD and then return to IDLE.
- Frame bits: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
- Valid frame (start=0, stop=1, odd parity over data+parity): load datos with frame[8:1] and pulse rx_done_tick in that same cycle.
- Invalid frame: pulse frame_err instead and leave datos unchanged.
REQ-019 SHALL have a latency of one cycle: rx_done_tick is high in the clk cycle after the one in which the 11th fall_edge occurred.
REQ-020 SHALL hold datos stable between rx_done_tick pulses.
REQ-021 SHALL never assert rx_done_tick and frame_err in the same cycle.
REQ-022 SHALL count a fall_edge that occurs in the LOAD cycle as a new frame start only if it persists into IDLE; edges that occur during LOAD itself are dropped.
REQ-023 SHALL never fire a filtered edge from a ps2c low glitch shorter than FILTER_LEN cycles.

Reset
REQ-024 SHALL, on reset=1, immediately and asynchronously clear the following.
- FSM to IDLE.
- Synchronizers and filter register to all ones; filtered clock to 1.
- Frame register, bit counter and timeout counter to 0.
- datos to 8'h00; rx_done_tick and frame_err to 0.
REQ-025 SHALL, on reset asserted mid-frame, discard the partial frame and produce no pulse after release.

Structure
REQ-026 SHALL place the state encoding (IDLE, DPS, LOAD), FRAME_BITS=11 and the default TIMEOUT_CYC in a shared package ps2_pkg.
REQ-027 SHALL implement the synchronizer, glitch filter and falling-edge detector as one sub-module, ps2_clk_filter, with outputs ps2c_filt and fall_edge.

Verification
REQ-028 SHALL cover valid frame: send 0x1C (parity bit 0) at a 12.5 kHz PS/2 clock -> one rx_done_tick, datos=8'h1C, frame_err stays 0.
REQ-029 SHALL cover back-to-back frames: send 0xF0 (parity 1) then 0x1C -> two rx_done_tick pulses, datos=8'hF0 then 8'h1C, no frame_err.
REQ-030 SHALL cover bad frames.
- Send 0x1C with parity bit 1 -> one frame_err pulse, no rx_done_tick, datos unchanged.
- Send 0x1C with stop bit 0 -> same response.
REQ-031 SHALL cover timeout: stop after 5 edges, wait TIMEOUT_CYC+10 cycles -> one frame_err pulse and state IDLE; a following 0x1C is received correctly.
REQ-032 SHALL cover glitch and enable.
- 3-cycle low glitch on ps2c mid-frame -> no extra bit, 0x1C still received.
- Frame sent with rx_en=0 -> no pulses.
REQ-033 SHALL cover reset after the 6th edge of 0x1C -> all outputs 0 immediately, no pulse after release; the next 0xF0 is received correctly.
